// File: rtl/traffic_ctrl_multi_if.sv
// -----------------------------------------------------------------------------
// traffic_ctrl_multi_if
// Bundles the control inputs and lamp/status outputs of traffic_ctrl_multi.
//   en         : advance enable (low freezes the controller)
//   flash_req  : level request for flashing-yellow mode
//   ped_req    : pedestrian request (pulse or level)
//   light      : per-direction one-hot lamps, slice d = [3d+2:3d]
//                (001 green, 010 yellow, 100 red, 000 dark)
//   active_dir : direction owning the current or most recent green
//   sec_left   : whole seconds left in the current phase, minus one
//   walk       : high only during the pedestrian WALK phase
// Modports: master drives the controls (bench/system side), slave is the
// controller.
// -----------------------------------------------------------------------------
interface traffic_ctrl_multi_if #(
  parameter int NUM_DIR = 2,
  parameter int SEC_W   = 8
);
  logic                   en;
  logic                   flash_req;
  logic                   ped_req;
  logic [3*NUM_DIR-1:0]   light;
  logic [1:0]             active_dir;
  logic [SEC_W-1:0]       sec_left;
  logic                   walk;

  modport master (
    output en, flash_req, ped_req,
    input  light, active_dir, sec_left, walk
  );

  modport slave (
    input  en, flash_req, ped_req,
    output light, active_dir, sec_left, walk
  );
endinterface

// File: rtl/traffic_ctrl_multi.sv
// -----------------------------------------------------------------------------
// traffic_ctrl_multi
// Multi-direction traffic light controller with flashing-yellow mode and an
// optional pedestrian walk phase (compiled in with macro TRAFFIC_PED_EN).
// Directions are served round-robin: GREEN -> YELLOW -> ALLRED -> next GREEN.
// Phase timing is in seconds derived from a free tick counter of
// TICKS_PER_SEC enabled clock cycles.
// Ports:
//   clk : clock, all logic on the rising edge
//   rst : synchronous active-high reset
//   bus : traffic_ctrl_multi_if.slave (en, flash_req, ped_req in;
//         light, active_dir, sec_left, walk out -- all outputs registered)
// -----------------------------------------------------------------------------
module traffic_ctrl_multi #(
  parameter int NUM_DIR       = 2,
  parameter int TICKS_PER_SEC = 100,
  parameter int SEC_W         = 8,
  parameter int GREEN_SEC     = 10,
  parameter int YELLOW_SEC    = 3,
  parameter int ALLRED_SEC    = 1,
  parameter int WALK_SEC      = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  traffic_ctrl_multi_if.slave  bus
);

  localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TW-1:0]    TICK_MAX  = TW'(TICKS_PER_SEC - 1);
  localparam logic [SEC_W-1:0] GREEN_LD  = SEC_W'(GREEN_SEC - 1);
  localparam logic [SEC_W-1:0] YELLOW_LD = SEC_W'(YELLOW_SEC - 1);
  localparam logic [SEC_W-1:0] ALLRED_LD = SEC_W'(ALLRED_SEC - 1);
  localparam logic [SEC_W-1:0] WALK_LD   = SEC_W'(WALK_SEC - 1);
  localparam logic [3*NUM_DIR-1:0] ALL_RED = {NUM_DIR{3'b100}};

  typedef enum logic [2:0] {
    IDLE, GREEN, YELLOW, ALLRED, WALK, FLASH
  } state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [SEC_W-1:0]      sec_q, sec_d;
  logic [1:0]            dir_q, dir_d;
  logic                  flash_on_q, flash_on_d;
  logic [3*NUM_DIR-1:0]  light_q, light_d;
  logic                  walk_q, walk_d;
  logic                  ped_q, ped_d;
  logic                  enter;
  logic                  sec_tick;
  logic                  phase_end;

  // Lamp pattern for a given state; computed from next-state values so the
  // lamps are registered together with the state they describe.
  function automatic logic [3*NUM_DIR-1:0] lamps(state_t st, logic [1:0] dir,
                                                 logic fon);
    logic [3*NUM_DIR-1:0] l;
    for (int d = 0; d < NUM_DIR; d++) begin
      l[3*d +: 3] = 3'b100;
      case (st)
        GREEN:   if (dir == 2'(d)) l[3*d +: 3] = 3'b001;
        YELLOW:  if (dir == 2'(d)) l[3*d +: 3] = 3'b010;
        FLASH:   l[3*d +: 3] = fon ? 3'b010 : 3'b000;
        default: ;
      endcase
    end
    return l;
  endfunction

  function automatic logic [1:0] next_dir(logic [1:0] dir);
    return (dir == 2'(NUM_DIR - 1)) ? 2'd0 : dir + 2'd1;
  endfunction

  assign sec_tick  = bus.en && (tick_q == TICK_MAX);
  assign phase_end = sec_tick && (sec_q == '0);

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    sec_d      = sec_q;
    dir_d      = dir_q;
    flash_on_d = flash_on_q;
    enter      = 1'b0;

    if (bus.en) begin
      tick_d = sec_tick ? '0 : tick_q + 1'b1;
      if (sec_tick && (sec_q != '0)) sec_d = sec_q - 1'b1;

      if (bus.flash_req) begin
        // Staying in FLASH is not a re-entry: keep the blink cadence running.
        if (state_q != FLASH) begin
          state_d = FLASH;
          enter   = 1'b1;
        end else if (sec_tick) begin
          flash_on_d = ~flash_on_q;
        end
      end else begin
        case (state_q)
          IDLE: begin
            state_d = GREEN;
            dir_d   = 2'd0;
            enter   = 1'b1;
          end
          GREEN: if (phase_end) begin
            state_d = YELLOW;
            enter   = 1'b1;
          end
          YELLOW: if (phase_end) begin
            state_d = ALLRED;
            enter   = 1'b1;
          end
          ALLRED: if (phase_end) begin
            enter = 1'b1;
`ifdef TRAFFIC_PED_EN
            if (ped_q) begin
              state_d = WALK;
            end else
`endif
            begin
              state_d = GREEN;
              dir_d   = next_dir(dir_q);
            end
          end
          WALK: if (phase_end) begin
            state_d = GREEN;
            dir_d   = next_dir(dir_q);
            enter   = 1'b1;
          end
          FLASH: begin
            // Park on the last direction so the next green is direction 0.
            state_d = ALLRED;
            dir_d   = 2'(NUM_DIR - 1);
            enter   = 1'b1;
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end

      if (enter) begin
        tick_d = '0;
        case (state_d)
          GREEN:   sec_d = GREEN_LD;
          YELLOW:  sec_d = YELLOW_LD;
          ALLRED:  sec_d = ALLRED_LD;
          WALK:    sec_d = WALK_LD;
          default: sec_d = '0;
        endcase
        if (state_d == FLASH) flash_on_d = 1'b1;
      end
    end

    light_d = lamps(state_d, dir_d, flash_on_d);
    walk_d  = (state_d == WALK);
  end

`ifdef TRAFFIC_PED_EN
  // Later assignments win: a request in the WALK-entry cycle re-arms the
  // pending flag, while entering FLASH discards any request.
  always_comb begin
    ped_d = ped_q;
    if (enter && (state_d == WALK)) ped_d = 1'b0;
    if (bus.ped_req)                ped_d = 1'b1;
    if (enter && (state_d == FLASH)) ped_d = 1'b0;
  end
`else
  logic unused_ped;
  assign unused_ped = bus.ped_req;
  assign ped_d      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      sec_q      <= '0;
      dir_q      <= 2'd0;
      flash_on_q <= 1'b0;
      light_q    <= ALL_RED;
      walk_q     <= 1'b0;
      ped_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      sec_q      <= sec_d;
      dir_q      <= dir_d;
      flash_on_q <= flash_on_d;
      light_q    <= light_d;
      walk_q     <= walk_d;
      ped_q      <= ped_d;
    end
  end

  assign bus.light      = light_q;
  assign bus.active_dir = dir_q;
  assign bus.sec_left   = sec_q;
  assign bus.walk       = walk_q;

endmodule

// File: doc/traffic_ctrl_multi.md
TRAFFIC_CTRL_MULTI -- requirements
Module: traffic_ctrl_multi

Interface
REQ-001 Parameter NUM_DIR, default 2, number of approach directions; legal range 2..4.
REQ-002 Parameter TICKS_PER_SEC, default 100, clk cycles per second tick; minimum 1.
REQ-003 Parameter SEC_W, default 8, width of all duration values and the sec_left output.
REQ-004 Parameters GREEN_SEC=10, YELLOW_SEC=3, ALLRED_SEC=1, WALK_SEC=5: phase durations in seconds; each 1..2^SEC_W-1.
REQ-005 clk  input  1  single clock; all logic on the rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 en  input  1  advance enable; low freezes state, counters and outputs.
REQ-008 flash_req  input  1  level request for flashing-yellow mode.
REQ-009 ped_req  input  1  pedestrian request pulse or level.
REQ-010 light  output  3*NUM_DIR  per-direction one-hot lamp, slice d = bits [3d+2:3d]: 001 green, 010 yellow, 100 red, 000 dark.
REQ-011 active_dir  output  2  index of the direction owning the current or most recent green.
REQ-012 sec_left  output  SEC_W  whole seconds remaining in the current phase, minus one.
REQ-013 walk  output  1  high only during the WALK phase.

Function
REQ-014 States: IDLE, GREEN, YELLOW, ALLRED, WALK, FLASH.
REQ-015 The tick counter counts 0..TICKS_PER_SEC-1 while en=1; sec_tick is asserted when it equals TICKS_PER_SEC-1, and the counter then wraps to 0.
REQ-016 On every phase entry: sec_left loads duration-1 and the tick counter clears.
REQ-017 On each sec_tick: sec_left decrements if nonzero; if zero, the phase ends. Each phase therefore lasts exactly duration*TICKS_PER_SEC enabled cycles.
REQ-018 IDLE with en=1: enter GREEN with active_dir=0 on the next edge.
REQ-019 Normal sequence: GREEN -> YELLOW -> ALLRED -> GREEN of (active_dir+1) mod NUM_DIR. active_dir updates on entry to GREEN.
REQ-020 Lamps in GREEN/YELLOW: active_dir slice shows 001/010 and all other slices 100. ALLRED, WALK and IDLE show 100 on every slice.
REQ-021 flash_req=1 with en=1 in any state: FLASH on the next edge, overriding all other transitions.
REQ-022 FLASH: every slice alternates between 010 and 000 on each sec_tick, starting at 010; sec_left holds 0.
REQ-023 flash_req=0 in FLASH: enter ALLRED (ALLRED_SEC) with active_dir forced to NUM_DIR-1, so the next GREEN is direction 0.
REQ-024 en=0: no state, counter or output change. ped_req is still latched if the feature is enabled (REQ-029).
REQ-025 All outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-026 rst=1 at a clock edge, in any state: state=IDLE, tick counter=0, sec_left=0, active_dir=0, walk=0, ped_pending=0, every light slice=100.
REQ-027 rst has priority over en, flash_req and ped_req.

Configuration
REQ-028 Macro TRAFFIC_PED_EN compiles in the pedestrian walk feature.
REQ-029 With TRAFFIC_PED_EN defined:
  - ped_req=1 sets ped_pending.
  - On ALLRED end with ped_pending=1: enter WALK (WALK_SEC, walk=1, all red) and clear ped_pending; WALK end -> GREEN of the next direction.
  - Entering FLASH clears ped_pending.
  - ped_req asserted in the same cycle as the WALK entry re-sets ped_pending.
REQ-030 Without TRAFFIC_PED_EN: ped_req is ignored, walk is tied 0, WALK is unreachable; ports are unchanged.

Verification
All scenarios use NUM_DIR=2, TICKS_PER_SEC=4, GREEN_SEC=3, YELLOW_SEC=1, ALLRED_SEC=1, WALK_SEC=2.
REQ-031 Reset, then en=1: light=100_001 for 12 cycles, 100_010 for 4, 100_100 for 4, then 001_100 with active_dir=1; sec_left in green reads 2,1,0.
REQ-032 en=0 for 7 cycles mid-GREEN: light and sec_left hold; the phase ends 7 cycles later than in REQ-031.
REQ-033 flash_req=1 during YELLOW: the next cycle light=010_010; it alternates with 000_000 every 4 cycles; after flash_req=0: 4 cycles of 100_100, then 100_001 with active_dir=0.
REQ-034 TRAFFIC_PED_EN defined, 1-cycle ped_req pulse during GREEN dir 0: after ALLRED, 8 cycles with walk=1 and light=100_100, then 001_100.
REQ-035 rst=1 mid-YELLOW for one cycle: the next cycle shows IDLE outputs (all 100, sec_left=0, walk=0); the sequence restarts at direction 0.
REQ-036 flash_req and ped_req asserted in the same cycle (TRAFFIC_PED_EN defined): FLASH entered, ped_pending=0, no WALK after flash exit.
